// File: rtl/fp8_e4m3_mac_core.sv
// fp8_e4m3_mac_core: FP8 E4M3 multiply-accumulate into a wide fixed-point accumulator,
// rounded back to E4M3 (round-to-nearest-even, saturating) only when read.
module fp8_e4m3_mac_core #(
    parameter int ACC_W = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] input_a,
    input  logic [7:0] input_b,
    input  logic       mac_start,
    input  logic       clear_acc,
    input  logic       read_enable,
    output logic [7:0] output_result,
    output logic       mac_done,
    output logic       ready_for_new
);
    typedef enum logic [1:0] {IDLE, MULT, ACC, DONE} state_t;
    localparam logic signed [ACC_W:0] LIM = {2'b00, {(ACC_W-1){1'b1}}};

    state_t                   state_q, state_d;
    logic [7:0]               a_q, a_d, b_q, b_d, out_q, out_d;
    logic signed [ACC_W-1:0]  prod_q, prod_d, acc_q, acc_d;
    logic                     nan_q, nan_d, done_q, done_d, ready_q, ready_d;
    logic                     start_ok, nan_op;
    logic [3:0]               sig_a, sig_b;
    logic [4:0]               exp_sum;
    logic [ACC_W-1:0]         prod_mag;
    logic signed [ACC_W:0]    sum, sat;

    always_comb begin
        start_ok = state_q == IDLE && mac_start;
        state_d  = state_q == IDLE ? (mac_start ? MULT : IDLE) :
                   state_q == MULT ? ACC : state_q == ACC ? DONE : IDLE;
        a_d      = start_ok ? input_a : a_q;
        b_d      = start_ok ? input_b : b_q;
        sig_a    = {|a_q[6:3], a_q[2:0]};
        sig_b    = {|b_q[6:3], b_q[2:0]};
        // Subnormals use effective exponent 1; product LSB lands on 2^-18 after shift of (ea+eb-2)
        exp_sum  = 5'(a_q[6:3]) + 5'(b_q[6:3]) + 5'(a_q[6:3] == 4'd0) + 5'(b_q[6:3] == 4'd0);
        prod_mag = ACC_W'(8'(sig_a) * 8'(sig_b)) << (exp_sum - 5'd2);
        prod_d   = state_q == MULT ? ((a_q[7] ^ b_q[7]) ? -$signed(prod_mag) : $signed(prod_mag)) : prod_q;
        nan_op   = a_q[6:0] == 7'h7F || b_q[6:0] == 7'h7F;
        sum      = (ACC_W+1)'(acc_q) + (ACC_W+1)'(prod_q);
        sat      = sum > LIM ? LIM : sum < -LIM ? -LIM : sum;
        acc_d    = clear_acc ? '0 : (state_q == ACC && !nan_op) ? ACC_W'(sat) : acc_q;
        nan_d    = clear_acc ? 1'b0 : (state_q == ACC && nan_op) ? 1'b1 : nan_q;
        done_d   = state_q == DONE;
        ready_d  = state_d == IDLE;
    end

    logic [ACC_W-1:0] mag, sh;
    logic [5:0]       p, e;
    logic [2:0]       m, m_new, q;
    logic [3:0]       mant, r;
    logic             s, g, st;
    logic [7:0]       norm_byte, sub_byte, conv;

    always_comb begin
        s    = acc_q[ACC_W-1];
        mag  = s ? ACC_W'(-acc_q) : ACC_W'(acc_q);
        p    = '0;
        for (int i = 0; i < ACC_W; i++)
            if (mag[i]) p = 6'(i);
        sh        = mag << (6'(ACC_W-1) - p);
        m         = sh[ACC_W-2 -: 3];
        g         = sh[ACC_W-5];
        st        = |sh[ACC_W-6:0];
        mant      = {1'b0, m} + 4'(g & (st | m[0]));
        m_new     = mant[3] ? 3'd0 : mant[2:0];
        e         = p - 6'd11 + 6'(mant[3]);
        norm_byte = (e > 6'd15 || (e == 6'd15 && m_new == 3'd7)) ? {s, 7'h7E} : {s, e[3:0], m_new};
        // Subnormal grid is 2^-9 = bit 9 of the fixed-point accumulator
        q         = mag[11:9];
        r         = {1'b0, q} + 4'(mag[8] & ((|mag[7:0]) | q[0]));
        sub_byte  = r == 4'd0 ? 8'h00 : {s, 3'b000, r};
        conv      = nan_q ? 8'h7F : mag == '0 ? 8'h00 : |mag[ACC_W-1:12] ? norm_byte : sub_byte;
        out_d     = read_enable ? conv : out_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            acc_q   <= '0;
            nan_q   <= 1'b0;
            out_q   <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            acc_q   <= acc_d;
            nan_q   <= nan_d;
            out_q   <= out_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign output_result = out_q;
    assign mac_done      = done_q;
    assign ready_for_new = ready_q;
endmodule

// File: tb/tb_fp8_e4m3_mac_core.sv
// tb_fp8_e4m3_mac_core: scoreboard bench; reads queue expected E4M3 values from an
// exact integer accumulator model with nearest-code search, a monitor compares them.
module tb_fp8_e4m3_mac_core;
    logic       clk = 0, rst = 1;
    logic [7:0] input_a = 0, input_b = 0;
    logic       mac_start = 0, clear_acc = 0, read_enable = 0;
    logic [7:0] output_result;
    logic       mac_done, ready_for_new;

    fp8_e4m3_mac_core dut (
        .clk(clk), .rst(rst), .input_a(input_a), .input_b(input_b),
        .mac_start(mac_start), .clear_acc(clear_acc), .read_enable(read_enable),
        .output_result(output_result), .mac_done(mac_done), .ready_for_new(ready_for_new)
    );

    always #5 clk = ~clk;

    int         compared = 0, mismatched = 0;
    logic [7:0] exp_q[$];
    longint     acc_m = 0;
    bit         nan_m = 0;
    localparam longint LIM = (longint'(1) << 47) - 1;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Value of an E4M3 code in units of 2^-9
    function automatic longint dec9(input logic [7:0] x);
        longint v;
        v = x[6:3] == 0 ? longint'(x[2:0]) : longint'(8 + x[2:0]) << (x[6:3] - 1);
        return x[7] ? -v : v;
    endfunction

    // Nearest finite E4M3 code to v (units 2^-18), ties to even code
    function automatic logic [7:0] ref_conv(input longint v, input bit nan);
        longint a, d, best_d;
        logic [7:0] best;
        if (nan) return 8'h7F;
        a = v < 0 ? -v : v;
        best = 0;
        best_d = a;
        for (int c = 1; c <= 126; c++) begin
            d = a - (dec9(8'(c)) << 9);
            if (d < 0) d = -d;
            if (d < best_d || (d == best_d && c % 2 == 0)) begin
                best_d = d;
                best = 8'(c);
            end
        end
        return best == 0 ? 8'h00 : {v < 0, best[6:0]};
    endfunction

    initial begin : monitor
        bit rd;
        forever begin
            @(posedge clk);
            rd = read_enable;
            #1;
            if (rd) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL read: unexpected result %02h, nothing expected", output_result);
                end else check("read", output_result, exp_q.pop_front());
            end
        end
    end

    task automatic read_push(input logic [7:0] exp);
        read_enable = 1;
        exp_q.push_back(exp);
        @(negedge clk);
        read_enable = 0;
    endtask

    task automatic read_model();
        read_push(ref_conv(acc_m, nan_m));
    endtask

    task automatic clear();
        clear_acc = 1;
        @(negedge clk);
        clear_acc = 0;
        acc_m = 0;
        nan_m = 0;
    endtask

    function automatic void model_mac(input logic [7:0] a, input logic [7:0] b);
        if (a[6:0] == 7'h7F || b[6:0] == 7'h7F) nan_m = 1;
        else begin
            acc_m += dec9(a) * dec9(b);
            if (acc_m > LIM) acc_m = LIM;
            if (acc_m < -LIM) acc_m = -LIM;
        end
    endfunction

    // mode 0: plain, 1: clear during ACC cycle, 2: clear together with start
    task automatic mac(input logic [7:0] a, input logic [7:0] b, input int mode = 0);
        check("ready_before_start", 8'(ready_for_new), 8'd1);
        input_a = a;
        input_b = b;
        mac_start = 1;
        clear_acc = mode == 2;
        @(negedge clk);
        mac_start = 0;
        clear_acc = 0;
        @(negedge clk);
        clear_acc = mode == 1;
        @(negedge clk);
        clear_acc = 0;
        check("done_early", 8'(mac_done), 8'd0);
        @(negedge clk);
        check("done_pulse", 8'(mac_done), 8'd1);
        if (mode == 1) begin
            acc_m = 0;
            nan_m = 0;
        end else begin
            if (mode == 2) begin
                acc_m = 0;
                nan_m = 0;
            end
            model_mac(a, b);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ra, rb;
        int sel;
        @(negedge clk);
        @(negedge clk);
        check("rst_out", output_result, 8'h00);
        check("rst_done", 8'(mac_done), 8'd0);
        check("rst_ready", 8'(ready_for_new), 8'd1);
        rst = 0;
        read_push(8'h00);

        // Latency, with busy starts carrying a NaN operand that must be ignored
        clear();
        input_a = 8'h38;
        input_b = 8'h40;
        mac_start = 1;
        @(negedge clk);
        input_a = 8'h7F;
        for (int i = 0; i < 3; i++) begin
            check("busy_ready", 8'(ready_for_new), 8'd0);
            check("busy_done", 8'(mac_done), 8'd0);
            if (i == 2) mac_start = 0;
            @(negedge clk);
        end
        check("lat_done", 8'(mac_done), 8'd1);
        check("lat_ready", 8'(ready_for_new), 8'd1);
        @(negedge clk);
        check("done_one_cycle", 8'(mac_done), 8'd0);
        model_mac(8'h38, 8'h40);
        read_push(8'h40);

        clear(); mac(8'h3C, 8'h3C); read_push(8'h41);
        mac(8'h3C, 8'h3C); read_push(8'h49);
        clear(); mac(8'h7E, 8'h7E); read_push(8'h7E);
        clear(); mac(8'hFE, 8'h7E); read_push(8'hFE);
        clear(); mac(8'h38, 8'h38); mac(8'hB8, 8'h38); read_push(8'h00);
        clear(); mac(8'h7F, 8'h38); read_push(8'h7F);
        mac(8'h38, 8'h38); read_push(8'h7F);
        clear(); read_push(8'h00);
        clear(); mac(8'h01, 8'h38); read_push(8'h01);
        clear(); mac(8'h01, 8'h01); read_push(8'h00);
        clear(); mac(8'h38, 8'h38); mac(8'h38, 8'h40, 1); read_push(8'h00);
        mac(8'h38, 8'h38); mac(8'h38, 8'h40, 2); read_push(8'h40);
        clear(); mac(8'h08, 8'h30); mac(8'h08, 8'h30); read_model();

        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 11);
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (sel == 0) clear();
            else if (sel <= 2) read_model();
            else if (sel == 3) mac(ra, rb, int'($urandom_range(1, 2)));
            else begin
                mac(ra, rb);
                if (sel > 8) read_model();
            end
        end
        read_model();
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d reads outstanding, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
